// File: rtl/cmsdk_eg_reg_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cmsdk_eg_reg_arbiter_if : two requester ports plus one register port  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface cmsdk_eg_reg_arbiter_if #(
    parameter int ADDRWIDTH = 12
);
    // Requester side
    logic                 req0;
    logic                 req1;
    logic                 write0;
    logic                 write1;
    logic [ADDRWIDTH-1:0] addr0;
    logic [ADDRWIDTH-1:0] addr1;
    logic [3:0]           strobe0;
    logic [3:0]           strobe1;
    logic [31:0]          wdata0;
    logic [31:0]          wdata1;
    logic                 ack0;
    logic                 ack1;
    logic [31:0]          rdata0;
    logic [31:0]          rdata1;
    // Register block side
    logic [ADDRWIDTH-1:0] addr;
    logic                 read_en;
    logic                 write_en;
    logic [3:0]           byte_strobe;
    logic [31:0]          wdata;
    logic [31:0]          rdata;
    logic                 busy;

    modport slave (
        input  req0, req1, write0, write1, addr0, addr1,
               strobe0, strobe1, wdata0, wdata1, rdata,
        output ack0, ack1, rdata0, rdata1, addr, read_en, write_en,
               byte_strobe, wdata, busy
    );

    modport master (
        output req0, req1, write0, write1, addr0, addr1,
               strobe0, strobe1, wdata0, wdata1, rdata,
        input  ack0, ack1, rdata0, rdata1, addr, read_en, write_en,
               byte_strobe, wdata, busy
    );
endinterface
`default_nettype wire

// File: rtl/cmsdk_eg_reg_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cmsdk_eg_reg_arbiter : round-robin arbiter, two requesters sharing    |
// | one example-slave register port. Rev 1.0                              |
// +----------------------------------------------------------------------+
module cmsdk_eg_reg_arbiter #(
    parameter int ADDRWIDTH = 12
) (
    input  wire logic              hclk,
    input  wire logic              hreset,
    cmsdk_eg_reg_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic                 r_prio;
    logic                 r_winner;
    logic                 r_read_en;
    logic                 r_write_en;
    logic                 r_ack0;
    logic                 r_ack1;
    logic                 r_busy;
    logic [ADDRWIDTH-1:0] r_addr;
    logic [3:0]           r_strobe;
    logic [31:0]          r_wdata;
    logic [31:0]          r_rdata0;
    logic [31:0]          r_rdata1;

    logic                 w_any_req;
    logic                 w_win;
    logic                 w_start;
    logic                 w_sel_write;
    logic [ADDRWIDTH-1:0] w_sel_addr;
    logic [3:0]           w_sel_strobe;
    logic [31:0]          w_sel_wdata;

    // Requester 1 wins when alone, or when both ask and the pointer favours it.
    always_comb begin
        w_any_req    = bus.req0 | bus.req1;
        w_win        = bus.req1 & (~bus.req0 | r_prio);
        w_start      = (r_state == ST_IDLE) & w_any_req;
        w_sel_write  = w_win ? bus.write1  : bus.write0;
        w_sel_addr   = w_win ? bus.addr1   : bus.addr0;
        w_sel_strobe = w_win ? bus.strobe1 : bus.strobe0;
        w_sel_wdata  = w_win ? bus.wdata1  : bus.wdata0;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_any_req) w_state_nxt = ST_ACCESS;
            ST_ACCESS: w_state_nxt = ST_DONE;
            ST_DONE:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            r_prio     <= 1'b0;
            r_winner   <= 1'b0;
            r_read_en  <= 1'b0;
            r_write_en <= 1'b0;
            r_ack0     <= 1'b0;
            r_ack1     <= 1'b0;
            r_busy     <= 1'b0;
            r_addr     <= '0;
            r_strobe   <= 4'h0;
            r_wdata    <= 32'h0;
            r_rdata0   <= 32'h0;
            r_rdata1   <= 32'h0;
        end else begin
            r_read_en  <= 1'b0;
            r_write_en <= 1'b0;
            r_ack0     <= 1'b0;
            r_ack1     <= 1'b0;

            if (w_start) begin
                r_winner   <= w_win;
                r_addr     <= w_sel_addr;
                r_strobe   <= w_sel_strobe;
                r_wdata    <= w_sel_wdata;
                r_read_en  <= ~w_sel_write;
                r_write_en <= w_sel_write;
                r_busy     <= 1'b1;
            end

            if (r_state == ST_ACCESS) begin
                // Read data is only valid during the read strobe; capture it for the winner alone.
                if (r_read_en) begin
                    if (r_winner) begin
                        r_rdata1 <= bus.rdata;
                    end else begin
                        r_rdata0 <= bus.rdata;
                    end
                end
                r_ack0 <= ~r_winner;
                r_ack1 <= r_winner;
            end

            if (r_state == ST_DONE) begin
                r_prio <= ~r_winner;
                r_busy <= 1'b0;
            end
        end
    end

    assign bus.ack0        = r_ack0;
    assign bus.ack1        = r_ack1;
    assign bus.rdata0      = r_rdata0;
    assign bus.rdata1      = r_rdata1;
    assign bus.addr        = r_addr;
    assign bus.read_en     = r_read_en;
    assign bus.write_en    = r_write_en;
    assign bus.byte_strobe = r_strobe;
    assign bus.wdata       = r_wdata;
    assign bus.busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_cmsdk_eg_reg_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_cmsdk_eg_reg_arbiter : directed and random checks of the arbiter   |
// | against a transfer-level model. Rev 1.0                               |
// +----------------------------------------------------------------------+
module tb_cmsdk_eg_reg_arbiter;
    localparam int AW = 12;

    logic hclk   = 1'b0;
    logic hreset = 1'b1;

    cmsdk_eg_reg_arbiter_if #(.ADDRWIDTH(AW)) bus ();

    cmsdk_eg_reg_arbiter #(.ADDRWIDTH(AW)) dut (
        .hclk   (hclk),
        .hreset (hreset),
        .bus    (bus)
    );

    always #5 hclk = ~hclk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit chk_en  = 1'b0;

    always @(posedge hclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transfer-level model: m_age counts cycles since a grant (-1 = no transfer).
    int          m_age   = -1;
    bit          m_prio  = 1'b0;
    bit          m_win   = 1'b0;
    bit          m_wr    = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [3:0]  m_strb  = 4'h0;
    logic [31:0] m_wdata = 32'h0;
    logic [31:0] m_rd0   = 32'h0;
    logic [31:0] m_rd1   = 32'h0;

    always @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            m_age <= -1; m_prio <= 1'b0; m_win <= 1'b0; m_wr <= 1'b0;
            m_addr <= '0; m_strb <= 4'h0; m_wdata <= 32'h0;
            m_rd0 <= 32'h0; m_rd1 <= 32'h0;
        end else if (m_age < 0) begin
            if (bus.req0 || bus.req1) begin
                if ((bus.req0 && bus.req1) ? m_prio : bus.req1) begin
                    m_win <= 1'b1; m_wr <= bus.write1; m_addr <= bus.addr1;
                    m_strb <= bus.strobe1; m_wdata <= bus.wdata1;
                end else begin
                    m_win <= 1'b0; m_wr <= bus.write0; m_addr <= bus.addr0;
                    m_strb <= bus.strobe0; m_wdata <= bus.wdata0;
                end
                m_age <= 0;
            end
        end else if (m_age == 0) begin
            if (!m_wr) begin
                if (m_win) m_rd1 <= bus.rdata;
                else       m_rd0 <= bus.rdata;
            end
            m_age <= 1;
        end else begin
            m_prio <= !m_win;
            m_age  <= -1;
        end
    end

    always @(negedge hclk) begin
        if (chk_en) begin
            check("read_en",     32'(bus.read_en),     32'(m_age == 0 && !m_wr));
            check("write_en",    32'(bus.write_en),    32'(m_age == 0 && m_wr));
            check("ack0",        32'(bus.ack0),        32'(m_age == 1 && !m_win));
            check("ack1",        32'(bus.ack1),        32'(m_age == 1 && m_win));
            check("busy",        32'(bus.busy),        32'(m_age >= 0));
            check("addr",        32'(bus.addr),        32'(m_addr));
            check("byte_strobe", 32'(bus.byte_strobe), 32'(m_strb));
            check("wdata",       bus.wdata,            m_wdata);
            check("rdata0",      bus.rdata0,           m_rd0);
            check("rdata1",      bus.rdata1,           m_rd1);
        end
    end

    task automatic step();
        @(posedge hclk);
        #2;
    endtask

    task automatic new_req0();
        bus.req0 = 1'b1; bus.write0 = 1'($urandom); bus.addr0 = AW'($urandom);
        bus.strobe0 = 4'($urandom); bus.wdata0 = $urandom;
    endtask

    task automatic new_req1();
        bus.req1 = 1'b1; bus.write1 = 1'($urandom); bus.addr1 = AW'($urandom);
        bus.strobe1 = 4'($urandom); bus.wdata1 = $urandom;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int we_cnt;
        int re_cnt;
        int low_cnt;
        int n_ack;
        int ack_win[4];
        int ack_off[4];
        int got;

        bus.req0 = 0; bus.req1 = 0; bus.write0 = 0; bus.write1 = 0;
        bus.addr0 = '0; bus.addr1 = '0; bus.strobe0 = 0; bus.strobe1 = 0;
        bus.wdata0 = 0; bus.wdata1 = 0; bus.rdata = 0;
        hreset = 1'b1;
        step(); step();
        chk_en = 1'b1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_addr", 32'(bus.addr), 32'd0);
        hreset = 1'b0;
        step(); step();

        // Single read on requester 1
        bus.req1 = 1; bus.write1 = 0; bus.addr1 = 12'h3FC; bus.strobe1 = 4'hF;
        bus.wdata1 = 32'h1234_5678; bus.rdata = 32'hDEADBEEF;
        step();
        check("rd_addr", 32'(bus.addr), 32'h3FC);
        check("rd_read_en", 32'(bus.read_en), 32'd1);
        step();
        check("rd_ack1", 32'(bus.ack1), 32'd1);
        check("rd_ack0", 32'(bus.ack0), 32'd0);
        check("rd_rdata1", bus.rdata1, 32'hDEADBEEF);
        check("rd_rdata0", bus.rdata0, 32'h0);
        bus.req1 = 0;
        step(); step();

        // Write with partial strobe on requester 0
        bus.req0 = 1; bus.write0 = 1; bus.addr0 = 12'h010; bus.strobe0 = 4'b0100;
        bus.wdata0 = 32'h00AB_0000; bus.rdata = 32'hCAFE_F00D;
        we_cnt = 0; re_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (bus.write_en) we_cnt++;
            if (bus.read_en)  re_cnt++;
            if (k == 0) begin
                check("wr_strobe", 32'(bus.byte_strobe), 32'h4);
                check("wr_wdata", bus.wdata, 32'h00AB_0000);
            end
            if (k == 1) begin
                check("wr_ack0", 32'(bus.ack0), 32'd1);
                bus.req0 = 0;
            end
        end
        check("wr_we_cycles", 32'(we_cnt), 32'd1);
        check("wr_re_cycles", 32'(re_cnt), 32'd0);
        check("wr_rdata0", bus.rdata0, 32'h0);
        check("wr_rdata1", bus.rdata1, 32'hDEADBEEF);

        // Reset pulse while idle clears the held register-port values
        hreset = 1'b1;
        #1;
        check("rstp_addr", 32'(bus.addr), 32'd0);
        check("rstp_strobe", 32'(bus.byte_strobe), 32'd0);
        check("rstp_wdata", bus.wdata, 32'h0);
        check("rstp_rdata1", bus.rdata1, 32'h0);
        check("rstp_busy", 32'(bus.busy), 32'd0);
        step();

        // Contention from reset: both held for 4 transfers
        hreset = 1'b0;
        bus.req0 = 1; bus.write0 = 0; bus.addr0 = 12'h100; bus.strobe0 = 4'hF;
        bus.req1 = 1; bus.write1 = 1; bus.addr1 = 12'h200; bus.strobe1 = 4'h3;
        c0 = cyc; n_ack = 0;
        for (int k = 0; k < 30 && n_ack < 4; k++) begin
            step();
            bus.rdata = $urandom;
            if (bus.ack0 || bus.ack1) begin
                ack_win[n_ack] = int'(bus.ack1);
                ack_off[n_ack] = cyc - c0;
                n_ack++;
            end
        end
        bus.req0 = 0; bus.req1 = 0;
        check("cont_acks", 32'(n_ack), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < n_ack) begin
                check("cont_winner", 32'(ack_win[i]), 32'(i % 2));
                check("cont_ack_cycle", 32'(ack_off[i]), 32'(2 + 3 * i));
            end
        end
        step(); step();

        // Back-to-back transfers from requester 0 alone
        bus.req0 = 1; bus.write0 = 0; bus.addr0 = 12'h044;
        n_ack = 0; low_cnt = 0;
        for (int k = 0; k < 30 && n_ack < 3; k++) begin
            step();
            bus.rdata = $urandom;
            if (n_ack > 0 && !bus.busy) low_cnt++;
            if (bus.ack0) begin
                if (n_ack < 4) ack_off[n_ack] = cyc;
                n_ack++;
            end
        end
        bus.req0 = 0;
        check("b2b_acks", 32'(n_ack), 32'd3);
        if (n_ack == 3) begin
            check("b2b_gap1", 32'(ack_off[1] - ack_off[0]), 32'd3);
            check("b2b_gap2", 32'(ack_off[2] - ack_off[1]), 32'd3);
        end
        check("b2b_busy_low", 32'(low_cnt), 32'd2);
        step(); step();

        // Reset during ACCESS aborts the transfer; held req is re-granted
        bus.req0 = 1; bus.write0 = 1; bus.addr0 = 12'h0F0; bus.wdata0 = 32'h5555_AAAA;
        step();
        check("abort_we_before", 32'(bus.write_en), 32'd1);
        #1 hreset = 1'b1;
        #1;
        check("abort_we", 32'(bus.write_en), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        step();
        check("abort_ack0", 32'(bus.ack0), 32'd0);
        hreset = 1'b0;
        c0 = cyc; got = -1;
        for (int k = 0; k < 10 && got < 0; k++) begin
            step();
            if (bus.ack0) got = cyc - c0;
        end
        check("abort_regrant", 32'(got), 32'd2);
        bus.req0 = 0;
        step();

        // Randomized traffic with occasional protocol violations and resets
        for (int k = 0; k < 500; k++) begin
            step();
            if (hreset) hreset = 1'b0;
            else if ($urandom_range(0, 99) == 0) hreset = 1'b1;
            bus.rdata = $urandom;
            if (bus.ack0 || (bus.req0 && $urandom_range(0, 39) == 0)) begin
                if ($urandom_range(0, 1) == 1) new_req0(); else bus.req0 = 0;
            end else if (!bus.req0 && $urandom_range(0, 2) == 0) begin
                new_req0();
            end
            if (bus.ack1 || (bus.req1 && $urandom_range(0, 39) == 0)) begin
                if ($urandom_range(0, 1) == 1) new_req1(); else bus.req1 = 0;
            end else if (!bus.req1 && $urandom_range(0, 2) == 0) begin
                new_req1();
            end
        end
        hreset = 1'b0; bus.req0 = 0; bus.req1 = 0;
        step(); step(); step(); step();
        chk_en = 1'b0;
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/cmsdk_eg_reg_arbiter.md
# cmsdk_eg_reg_arbiter

Two-requester arbiter sharing one example-slave register interface (addr / read_en / write_en / byte_strobe / wdata / rdata) between independent register-bus masters, e.g. the AHB slave interface and a local configuration sequencer. It accepts one transfer at a time from a req/ack handshake on each port. It grants with round-robin fairness and drives exactly one single-cycle register access per grant. It returns read data to the winning requester.

## Interface
- ADDRWIDTH, 12, register address width (matches register block)
- hclk  in  1  clock, all state on rising edge
- hreset  in  1  reset; asynchronous assert, active-high; synchronously released by system
- req0 / req1  in  1  transfer request; held high with fields stable until matching ack
- write0 / write1  in  1  1 = write, 0 = read
- addr0 / addr1  in  ADDRWIDTH  register address
- strobe0 / strobe1  in  4  byte strobe
- wdata0 / wdata1  in  32  write data
- ack0 / ack1  out  1  single-cycle completion pulse
- rdata0 / rdata1  out  32  read data; valid in ack cycle, held until next read completion on that port
- addr  out  ADDRWIDTH  register address, registered
- read_en  out  1  register read strobe, one cycle
- write_en  out  1  register write strobe, one cycle
- byte_strobe  out  4  registered copy of winner's strobe
- wdata  out  32  registered copy of winner's wdata
- rdata  in  32  register read data, valid combinationally in read_en cycle
- busy  out  1  high in ACCESS and DONE

## Operation
- FSM states:
  - IDLE: no transfer in progress.
  - ACCESS: read_en or write_en high.
  - DONE: winner's ack high.
- Transitions: IDLE -> ACCESS when req0|req1; ACCESS -> DONE unconditionally; DONE -> IDLE unconditionally.
- Arbitration happens in IDLE only. One requester: it wins. Both: the favoured one wins, using a 1-bit pointer `prio`.
- prio reset 0 (requester 0 favoured). On each DONE, prio is set to the non-winner, so a requester never wins twice while the other waits.
- On IDLE->ACCESS, winner's addr, strobe, wdata and write are registered onto addr/byte_strobe/wdata, and the winner id is latched.
- ACCESS:
  - read_en = ~write_latched; write_en = write_latched; exactly one cycle.
  - On a read, rdata is sampled at the end of ACCESS into the winner's rdataN register.
  - The loser's rdata register is never touched. Writes never touch either rdata register.
- DONE: ackN = 1 for the winner only; the other ack stays 0.
- addr/byte_strobe/wdata hold their last values while idle (no return to 0).
- A req still high in the IDLE cycle after DONE is a new transfer (back-to-back allowed).
- A requester dropping req during ACCESS/DONE (protocol violation): the transfer still completes and ack is still pulsed.
- Req fields are sampled only on the IDLE->ACCESS edge; later changes are ignored.
- read_en and write_en are never high simultaneously. Neither ack is high outside DONE.

## Timing
- Reset values: state IDLE, prio 0, read_en 0, write_en 0, ack0 0, ack1 0, busy 0, addr 0, byte_strobe 0, wdata 0, rdata0 0, rdata1 0.
- Latency: req high in cycle T (FSM in IDLE) -> read_en/write_en in T+1 -> ack and rdataN valid in T+2.
- Throughput: one transfer per 3 cycles. Alternating requesters under continuous contention.
- Reset asserted in any state: immediate return to reset values. The in-flight transfer is aborted with no ack, and the requester must re-issue. An abort during ACCESS may or may not have updated the register block.
- All outputs are registered except none; there is no combinational path from req to any output.

## Test plan
- Reset: hreset pulse mid-idle -> all outputs at reset values listed; busy 0; prio favours requester 0.
- Single read: req1=1, write1=0, addr1=0x3FC, strobe1=4'hF; rdata=0xDEADBEEF in read_en cycle.
  - Expect addr=0x3FC, read_en=1 at T+1; ack1=1, rdata1=0xDEADBEEF at T+2.
  - Expect ack0=0 and rdata0 unchanged.
- Simultaneous contention: req0 and req1 both held high for 4 transfers from reset.
  - Expect grant order 0,1,0,1 and acks at T+2, T+5, T+8, T+11.
- Write with strobe: req0 write, addr0=0x010, strobe0=4'b0100, wdata0=0x00AB0000.
  - Expect write_en=1 for exactly one cycle with byte_strobe=4'b0100 and wdata=0x00AB0000.
  - Expect read_en=0 throughout and rdata0 unchanged.
- Back-to-back: req0 held high for 3 transfers, req1 low.
  - Expect 3 grants to requester 0 with ack0 every 3rd cycle and busy low for exactly one cycle between transfers.
- Reset mid-operation: assert hreset while FSM is in ACCESS.
  - Expect read_en/write_en drop immediately, no ack0/ack1 pulse, state IDLE after release.
  - A held req is re-granted 2 cycles after release with ack at the expected latency.
